digit_entry: RTL and testbench
==============================

# digit_entry

Front-end digit entry stage for the four-digit number lock. It takes the four raw toggle-switch inputs used to step the password digits and synchronizes and debounces each one onto the system clock. A debounced rising edge becomes a single increment of a modulo-10 digit register. The four digits, press strobes and change strobe feed the lock core and the right-hand display scanner, so no switch ever acts as a clock.

## Interface
- DB_CYCLES, 1000000: consecutive cycles a synchronized input must hold a new level before it is accepted (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20: width of each debounce counter.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- key  in  4  raw switch levels; bit i steps digit i; asynchronous to clk.
- en  in  1  entry enabled (lock in set-password or enter-password mode).
- clr  in  1  synchronous digit clear (input reset, or timeout lockout).
- d0, d1, d2, d3  out  4 each  current digit values, 0..9.
- press  out  4  one-cycle strobe per channel on each accepted rising edge.
- changed  out  1  one-cycle strobe: at least one digit value changed on the previous edge.

## Operation
- Per channel: 2-flop synchronizer (s1, s2), debounce counter cnt[CNT_W], accepted level stb.
- Debounce rule:
  - If s2 == stb: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stb <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES cycles never changes stb.
- press[i] <= stb[i] rises this edge (registered; exactly one cycle). Falling edges produce nothing.
- Digit update, evaluated per channel in priority order:
  1. clr = 1: digit <= 0, regardless of en or press.
  2. en = 1 and press[i] = 1: digit <= (digit == 9) ? 0 : digit+1.
  3. Otherwise: hold.
- press is generated even when en = 0 or clr = 1; only the digit update is gated. A press while disabled is lost, not queued.
- Simultaneous presses on several channels each increment their own digit in the same cycle.
- changed <= 1 on the cycle after any digit register took a new value. A clr on digits already at 0 does not assert changed.
- Digit values never exceed 9; the arithmetic is 4-bit with explicit wrap at 9.

## Timing
- Reset values: s1 = s2 = stb = 0, cnt = 0, d0..d3 = 0, press = 0, changed = 0.
- Latency, raw key rising at edge N (stable thereafter):
  - s2 = 1 after edge N+2.
  - stb = 1 after edge N+2+DB_CYCLES.
  - press high during the following cycle.
  - Digit increments one edge later.
  - changed high one cycle after that.
- A switch held high through reset release is treated as a fresh press: one strobe after debounce.
- Reset mid-debounce discards the partial count; no pulse results from pre-reset activity.
- clr and press in the same cycle: the digit reads 0, not 1.
- Throughput: at most one increment per channel per 2×DB_CYCLES cycles, since a full press-release is required.

## Structure
- Shared package lock_pkg: DIGIT_MAX = 9, DIGIT_W = 4, default DB_CYCLES, and NUM_DIGITS = 4. The lock core and the display already use the digit constants.
- Sub-module key_debounce: synchronizer, counter, stb and press for one channel, parameterized by DB_CYCLES and CNT_W, instantiated four times.
- Digit registers, clr/en gating and changed are in digit_entry itself.

## Test plan
Use DB_CYCLES = 4 for all scenarios.
- Reset then idle: all outputs 0 for 20 cycles with key = 0000.
- Clean press: key[0] held high from edge 10 → press[0] high only in cycle 17, d0 = 1 from cycle 18, changed high in cycle 19; release and repeat 10 times → d0 = 0 (wrap 9 → 0).
- Glitch rejection: key[2] high for 3 cycles then low → no press[2], d2 stays 0; high for 4+ cycles → exactly one press.
- Gating:
  - en = 0 with a press on key[1] → press[1] pulses, d1 unchanged.
  - clr asserted in the same cycle as press[3] with d3 = 5 → d3 = 0.
- Simultaneous: all four keys rise on the same edge with d = 9,3,0,8 → d = 0,4,1,9 on the same cycle, one changed strobe.
- Reset mid-operation: rst during cnt = 2 with key[0] high → after release, press[0] fires 7 cycles later (2 sync + 4 debounce + 1), d0 = 1.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: digit constants, debounce defaults and digit arithmetic shared by the lock
package lock_pkg;
    localparam int DIGIT_MAX         = 9;
    localparam int DIGIT_W           = 4;
    localparam int NUM_DIGITS        = 4;
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT     = 20;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic digit_t digit_inc(input digit_t d);
        return (d == digit_t'(DIGIT_MAX)) ? '0 : d + digit_t'(1);
    endfunction
endpackage

// File: rtl/digit_entry_if.sv
// digit_entry_if: raw keys and controls in, digits and strobes out
interface digit_entry_if;
    import lock_pkg::*;
    logic [NUM_DIGITS-1:0] i_key;
    logic                  i_en;
    logic                  i_clr;
    digit_t                o_d0;
    digit_t                o_d1;
    digit_t                o_d2;
    digit_t                o_d3;
    logic [NUM_DIGITS-1:0] o_press;
    logic                  o_changed;

    modport master (
        output i_key, i_en, i_clr,
        input  o_d0, o_d1, o_d2, o_d3, o_press, o_changed
    );

    modport slave (
        input  i_key, i_en, i_clr,
        output o_d0, o_d1, o_d2, o_d3, o_press, o_changed
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronize one raw switch, debounce it and strobe on each accepted rise
module key_debounce
    import lock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press
);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stb;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // two-flop sync, then a new level must persist DB_CYCLES samples before it is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_stb   <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_key;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_stb) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                r_stb   <= r_s2;
                r_cnt   <= '0;
                r_press <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/digit_entry.sv
// digit_entry: four debounced key channels stepping modulo-10 digit registers
module digit_entry
    import lock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input logic         clk,
    input logic         rst,
    digit_entry_if.slave bus
);
    logic [NUM_DIGITS-1:0] w_press;
    digit_t                w_next  [NUM_DIGITS];
    logic                  w_diff;
    digit_t                r_digit [NUM_DIGITS];
    logic                  r_upd;
    logic                  r_changed;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_ch
        key_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_key  (bus.i_key[g]),
            .o_press(w_press[g])
        );
    end

    // clear beats an enabled press; a press while disabled is simply dropped
    always_comb begin
        w_diff = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_next[i] = bus.i_clr ? '0 : (bus.i_en && w_press[i]) ? digit_inc(r_digit[i]) : r_digit[i];
            w_diff    = w_diff | (w_next[i] != r_digit[i]);
        end
    end

    // digit registers; changed trails the digit update by one cycle via r_upd
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
            r_upd     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_next[i];
            r_upd     <= w_diff;
            r_changed <= r_upd;
        end
    end

    assign bus.o_d0      = r_digit[0];
    assign bus.o_d1      = r_digit[1];
    assign bus.o_d2      = r_digit[2];
    assign bus.o_d3      = r_digit[3];
    assign bus.o_press   = w_press;
    assign bus.o_changed = r_changed;
endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: scoreboard bench for the debounced digit entry stage
module tb_digit_entry;
    localparam int DB = 4;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] digits;
        logic        chg;
        int          cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    int     stage = 0;
    bit     mon_on = 1'b0;
    int     m [4] = '{0, 0, 0, 0};
    exp_t   q [$];
    exp_t   cur;

    digit_entry_if bus();

    digit_entry #(.DB_CYCLES(DB), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_digits();
        return {4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0])};
    endfunction

    // monitor: pops an expectation on every press strobe, then checks digits and changed
    always @(negedge clk) begin
        if (rst || !mon_on) begin
            stage = 0;
        end else if (stage == 1) begin
            check("digits", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0}, cur.digits);
            check("press_width", bus.o_press, 0);
            stage = 2;
        end else if (stage == 2) begin
            check("changed", bus.o_changed, cur.chg);
            stage = 0;
        end else begin
            check("changed_idle", bus.o_changed, 0);
            if (bus.o_press != 0) begin
                if (q.size() == 0) begin
                    check("press_unexpected", bus.o_press, 0);
                end else begin
                    cur = q.pop_front();
                    check("press_mask", bus.o_press, cur.mask);
                    check("press_cycle", cyc, cur.cyc);
                    stage = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q.size() != 0 || stage != 0); i++) tick(1);
        check("drain", q.size(), 0);
    endtask

    task automatic push_exp(input logic [3:0] mask, input logic chg);
        exp_t e;
        e.mask   = mask;
        e.digits = model_digits();
        e.chg    = chg;
        e.cyc    = cyc + 2 + DB;
        q.push_back(e);
    endtask

    task automatic press(input logic [3:0] mask);
        logic ch;
        ch = 1'b0;
        if (bus.i_en)
            for (int i = 0; i < 4; i++)
                if (mask[i]) begin
                    m[i] = (m[i] + 1) % 10;
                    ch = 1'b1;
                end
        push_exp(mask, ch);
        bus.i_key = bus.i_key | mask;
        tick(DB + 6);
        bus.i_key = bus.i_key & ~mask;
        tick(DB + 6);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_key = '0;
        bus.i_en  = 1'b1;
        bus.i_clr = 1'b0;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("reset_idle", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0, bus.o_press, bus.o_changed}, 0);
        end
        mon_on = 1'b1;

        for (int i = 0; i < 10; i++) press(4'b0001);
        check("wrap_d0", bus.o_d0, 0);

        for (int i = 0; i < 5; i++) press(4'b1000);
        check("d3_five", bus.o_d3, 5);

        m[3] = 0;
        push_exp(4'b1000, 1'b1);
        bus.i_key[3] = 1'b1;
        tick(2 + DB);
        bus.i_clr = 1'b1;
        tick(1);
        bus.i_clr = 1'b0;
        tick(4);
        bus.i_key[3] = 1'b0;
        tick(DB + 6);
        drain();
        check("clr_beats_press", bus.o_d3, 0);

        bus.i_clr = 1'b1;
        tick(1);
        bus.i_clr = 1'b0;
        tick(4);
        check("clr_on_zero", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0}, 0);

        bus.i_en = 1'b0;
        press(4'b0010);
        bus.i_en = 1'b1;
        check("disabled_d1", bus.o_d1, 0);

        for (int i = 0; i < 9; i++) press({i < 8, 1'b0, i < 3, 1'b1});
        check("preset_9308", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0}, 16'h8039);
        press(4'b1111);
        check("simultaneous", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0}, 16'h9140);

        bus.i_key[2] = 1'b1;
        tick(DB - 1);
        bus.i_key[2] = 1'b0;
        tick(DB + 8);
        check("glitch_d2", bus.o_d2, 1);

        m[2] = (m[2] + 1) % 10;
        push_exp(4'b0100, 1'b1);
        bus.i_key[2] = 1'b1;
        tick(DB);
        bus.i_key[2] = 1'b0;
        tick(DB + 8);
        drain();
        check("min_pulse_d2", bus.o_d2, 2);

        bus.i_key[0] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        m = '{1, 0, 0, 0};
        push_exp(4'b0001, 1'b1);
        rst = 1'b0;
        tick(DB + 6);
        bus.i_key[0] = 1'b0;
        tick(DB + 6);
        drain();
        check("reset_mid_d", {bus.o_d3, bus.o_d2, bus.o_d1, bus.o_d0}, 16'h0001);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
